// File: rtl/qacc_seq.sv
// rtl/qacc_seq.sv - sequential Q-format accumulator over a counted stream of product terms
// Saturating accumulation is enabled by defining QACC_SATURATE_EN; the default build wraps.
module qacc_seq #(
  parameter int Q     = 18,
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_ovr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_ovr,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The binary point is only a labelling convention here; addition is format-agnostic.
  localparam int FRAC_BITS = Q;

  localparam logic [N-1:0] ACC_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] ACC_MIN = {1'b1, {(N-1){1'b0}}};

  state_t             state_q;
  logic [N-1:0]       acc_q;
  logic [N-1:0]       acc_d;
  logic [LEN_W-1:0]   cnt_q;
  logic               ovr_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [N:0]         sum_ext;
  logic               add_ovf;
  logic               xfer;
  logic               last_xfer;

  assign xfer      = in_valid && in_ready_q;
  assign last_xfer = xfer && (cnt_q == LEN_W'(1));

  // Sign-extend both operands so bit N captures the true sign of the sum.
  always_comb begin
    sum_ext = {acc_q[N-1], acc_q} + {in_data[N-1], in_data};
    add_ovf = sum_ext[N] ^ sum_ext[N-1];
    acc_d   = sum_ext[N-1:0];
`ifdef QACC_SATURATE_EN
    if (add_ovf) begin
      acc_d = sum_ext[N] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovr_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              cnt_q      <= len;
              in_ready_q <= 1'b1;
              state_q    <= S_ACCUM;
            end else begin
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_ACCUM: begin
          if (xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - LEN_W'(1);
            ovr_q <= ovr_q | in_ovr | add_ovf;
            if (last_xfer) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // Result lanes are forced quiet outside DONE so idle buses carry no stale sums.
  assign out_data  = out_valid_q ? acc_q : '0;
  assign out_ovr   = out_valid_q & ovr_q;

  logic unused_frac;
  assign unused_frac = (FRAC_BITS < 0);

endmodule

// File: tb/tb_qacc_seq.sv
// tb/tb_qacc_seq.sv - directed self-checking bench for qacc_seq
module tb_qacc_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_ovr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] held;

  qacc_seq #(.Q(18), .N(32), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovr    (in_ovr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovr   (out_ovr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"},  out_data,           32'd0);
    chk({tag, "_out_ovr"},   {31'd0, out_ovr},   32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  task automatic launch(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic send(input logic [31:0] d, input logic ovr);
    in_valid = 1'b1;
    in_data  = d;
    in_ovr   = ovr;
    tick();
    in_valid = 1'b0;
    in_data  = 32'd0;
    in_ovr   = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 32'd0; in_ovr = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();

    // 1.0 + 2.0 - 0.5 = 2.5 in Q18
    launch(8'd3);
    chk("sum3_in_ready", {31'd0, in_ready}, 32'd1);
    chk("sum3_busy",     {31'd0, busy},     32'd1);
    send(32'h0004_0000, 1'b0);
    send(32'h0008_0000, 1'b0);
    chk("sum3_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(32'hFFFE_0000, 1'b0);
    chk("sum3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sum3_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("sum3_out_data", out_data, 32'h000A_0000);
    chk("sum3_out_ovr", {31'd0, out_ovr}, 32'd0);
    drain();
    chk_idle("sum3_after");

    // len=0 goes straight to DONE with a zero result
    launch(8'd0);
    chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
    chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("len0_out_data", out_data, 32'd0);
    chk("len0_out_ovr", {31'd0, out_ovr}, 32'd0);
    drain();
    chk_idle("len0_after");

    // positive overflow
    launch(8'd2);
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h0000_0001, 1'b0);
    chk("ovf_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef QACC_SATURATE_EN
    chk("ovf_out_data", out_data, 32'h7FFF_FFFF);
`else
    chk("ovf_out_data", out_data, 32'h8000_0000);
`endif
    chk("ovf_out_ovr", {31'd0, out_ovr}, 32'd1);
    drain();
    chk_idle("ovf_after");

    // gapped input with upstream overflow flag on the second term
    launch(8'd2);
    send(32'h0001_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
      chk("gap_out_valid", {31'd0, out_valid}, 32'd0);
    end
    send(32'h0002_0000, 1'b1);
    chk("gap_out_valid_final", {31'd0, out_valid}, 32'd1);
    chk("gap_out_data", out_data, 32'h0003_0000);
    chk("gap_out_ovr", {31'd0, out_ovr}, 32'd1);
    drain();
    chk_idle("gap_after");

    // backpressure in DONE while start is pulsed
    launch(8'd1);
    send(32'h0005_0000, 1'b0);
    held = 32'h0005_0000;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 8'd1;
      tick();
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", out_data, held);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0;
    len   = 8'd0;
    drain();
    chk_idle("hold_after");
    tick();
    chk_idle("hold_no_relaunch");

    // reset mid-accumulation discards the partial sum
    launch(8'd3);
    send(32'h0001_0000, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_idle("midreset");
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle("midreset_quiet");
    launch(8'd1);
    send(32'h1234_5678, 1'b0);
    chk("rerun_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rerun_out_data", out_data, 32'h1234_5678);
    chk("rerun_out_ovr", {31'd0, out_ovr}, 32'd0);
    drain();
    chk_idle("rerun_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qacc_seq.md
QACC_SEQ -- requirements
Module: qacc_seq

Interface
REQ-001 Parameter Q, default 18, fraction bits of every fixed-point operand.
REQ-002 Parameter N, default 32, total word width, two's complement.
REQ-003 Parameter LEN_W, default 8, width of the term-count input.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request a new accumulation; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of terms, sampled with start.
REQ-008 in_valid  input  1  in_data/in_ovr hold a product term.
REQ-009 in_ready  output  1  block accepts a term this cycle.
REQ-010 in_data  input  N  signed Q-format product from the upstream multiplier.
REQ-011 in_ovr  input  1  upstream multiplier overflow flag for this term.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 out_data  output  N  signed Q-format accumulated sum.
REQ-015 out_ovr  output  1  sticky overflow for this result.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-018 In IDLE, start=1 with len>0 SHALL clear acc and ovr, load cnt=len, and enter ACCUM next cycle.
REQ-019 In IDLE, start=1 with len=0 SHALL clear acc and ovr and enter DONE next cycle (result 0).
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 in_ready SHALL be 1 only in ACCUM; a term transfers on a cycle with in_valid=1 and in_ready=1.
REQ-022 On each transfer: acc <= acc + in_data, computed at N+1 bits; cnt decrements; ovr |= in_ovr | add-overflow.
REQ-023 Add-overflow SHALL be the two top bits of the N+1-bit sum differing.
REQ-024 The transfer with cnt=1 SHALL move the FSM to DONE; out_valid SHALL rise the following cycle (latency 1 after the last term).
REQ-025 In DONE, out_valid=1; out_data=acc and out_ovr=ovr; both SHALL stay stable until out_ready=1.
REQ-026 out_valid=1 with out_ready=1 SHALL return the FSM to IDLE next cycle; the earliest back-to-back start is that IDLE cycle.
REQ-027 Cycles in ACCUM with in_valid=0 SHALL change no state.
REQ-028 out_data and out_ovr SHALL be 0 whenever out_valid=0.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, acc=0, cnt=0, ovr=0, in_ready=0, out_valid=0, out_data=0, out_ovr=0, busy=0.
REQ-030 Reset in ACCUM or DONE SHALL discard the partial or pending result; no out_valid follows.

Configuration
REQ-031 Macro QACC_SATURATE_EN defined: on add-overflow, acc SHALL clamp to 2^(N-1)-1 on positive overflow or -2^(N-1) on negative overflow, and later terms add to the clamped value.
REQ-032 Macro QACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^N; out_ovr reporting is identical in both builds.

Verification
REQ-033 len=3; terms 0x00040000, 0x00080000, 0xFFFE0000 (1.0, 2.0, -0.5) -> out_data=0x000A0000 (2.5), out_ovr=0, out_valid one cycle after the third transfer.
REQ-034 start with len=0 -> out_valid next cycle, out_data=0x00000000, out_ovr=0, no in_ready pulse.
REQ-035 len=2; terms 0x7FFFFFFF, 0x00000001 -> with QACC_SATURATE_EN: out_data=0x7FFFFFFF, out_ovr=1; without it: out_data=0x80000000, out_ovr=1.
REQ-036 len=2; second term has in_ovr=1 and in_valid is gapped 3 cycles between terms -> out_ovr=1, sum correct, no term lost.
REQ-037 Hold out_ready=0 for 5 cycles in DONE while pulsing start -> out_data stable and start ignored; out_ready=1 -> IDLE next cycle.
REQ-038 Assert rst_n=0 after 1 of 3 terms -> next cycle all outputs 0; a new len=1 run afterwards returns exactly its single term.
